// File: rtl/display_page_ctrl.sv
// Page/freeze front end for a 4-digit hex display: debounced switch selects the
// 16-bit half of a 32-bit snapshot, debounced button freezes it; change flag and blink.
`timescale 1ns/1ps
module display_page_ctrl #(
   parameter int DEB_CYCLES   = 240000,
   parameter int FLAG_CYCLES  = 12000000,
   parameter int BLINK_CYCLES = 6000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] data_in,
   input  logic        sw_page,
   input  logic        key_freeze_n,
   output logic [15:0] disp_word,
   output logic        page,
   output logic        frozen,
   output logic        new_flag,
   output logic        blank
);

   localparam int DATA_W = 32;
   localparam int HALF_W = DATA_W / 2;
   localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
   localparam int FLAG_W = $clog2(FLAG_CYCLES + 1);
   localparam int BLK_W  = $clog2(BLINK_CYCLES + 1);

   localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
   localparam logic [DEB_W-1:0]  DEB_MAX   = '1;
   localparam logic [FLAG_W-1:0] FLAG_LOAD = FLAG_W'(FLAG_CYCLES);
   localparam logic [BLK_W-1:0]  BLK_LAST  = BLK_W'(BLINK_CYCLES - 1);

   typedef enum logic {LIVE = 1'b0, FROZEN = 1'b1} state_t;

   state_t state_q, state_d;

   logic              sw_s1, sw_s2, key_s1, key_s2;
   logic [DEB_W-1:0]  sw_cnt, key_cnt;
   logic              key_lvl;
   logic              sw_accept, key_accept, key_press;
   logic              vld_p0;
   logic [DATA_W-1:0] snap_p0;
   logic [HALF_W-1:0] disp_p1;
   logic [FLAG_W-1:0] flag_cnt;
   logic [BLK_W-1:0]  blk_cnt;

   // Key synchronizer idles at the released level so a button held through
   // reset is only seen after the full synchronizer + debounce path.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sw_s1  <= 1'b0;
         sw_s2  <= 1'b0;
         key_s1 <= 1'b1;
         key_s2 <= 1'b1;
      end else begin
         sw_s1  <= sw_page;
         sw_s2  <= sw_s1;
         key_s1 <= key_freeze_n;
         key_s2 <= key_s1;
      end
   end

   assign sw_accept  = (sw_s2 != page) && (sw_cnt == DEB_LAST);
   assign key_accept = (key_s2 != key_lvl) && (key_cnt == DEB_LAST);
   assign key_press  = key_accept && !key_s2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         page   <= 1'b0;
         sw_cnt <= '0;
      end else if (sw_s2 == page) begin
         sw_cnt <= '0;
      end else if (sw_accept) begin
         page   <= sw_s2;
         sw_cnt <= '0;
      end else if (sw_cnt != DEB_MAX) begin
         sw_cnt <= sw_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_lvl <= 1'b1;
         key_cnt <= '0;
      end else if (key_s2 == key_lvl) begin
         key_cnt <= '0;
      end else if (key_accept) begin
         key_lvl <= key_s2;
         key_cnt <= '0;
      end else if (key_cnt != DEB_MAX) begin
         key_cnt <= key_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= LIVE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (key_press) state_d = (state_q == LIVE) ? FROZEN : LIVE;
   end

   assign frozen = (state_q == FROZEN);
   assign vld_p0 = (state_q == LIVE);

   // p0: snapshot capture and change detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         snap_p0  <= '0;
         flag_cnt <= '0;
      end else begin
         if (vld_p0) snap_p0 <= data_in;
         if (vld_p0 && (data_in != snap_p0)) flag_cnt <= FLAG_LOAD;
         else if (flag_cnt != '0)             flag_cnt <= flag_cnt - 1'b1;
      end
   end

   assign new_flag = (flag_cnt != '0);

   // p1: halfword select toward the digit decoders
   always_ff @(posedge clk or posedge rst) begin
      if (rst) disp_p1 <= '0;
      else     disp_p1 <= page ? snap_p0[DATA_W-1:HALF_W] : snap_p0[HALF_W-1:0];
   end

   assign disp_word = disp_p1;

   // Blink phase restarts on every entry into and exit from FROZEN.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blk_cnt <= '0;
         blank   <= 1'b0;
      end else if ((state_q == FROZEN) && (state_d == FROZEN)) begin
         if (blk_cnt == BLK_LAST) begin
            blk_cnt <= '0;
            blank   <= ~blank;
         end else begin
            blk_cnt <= blk_cnt + 1'b1;
         end
      end else begin
         blk_cnt <= '0;
         blank   <= 1'b0;
      end
   end

endmodule
